// File: rtl/dvp_tx_pkg.sv
// Shared types and helpers for the DVP RGB565 transmitter.
// Holds the frame FSM states, the counter width and the RGB888 to RGB565 packer.
package dvp_tx_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBP    = 3'd2,
    ACTIVE = 3'd3,
    VFP    = 3'd4
  } dvp_state_e;

  // {R,G,B} 8:8:8 -> {R[7:3], G[7:2], B[7:3]}; byte [15:8] goes out first.
  function automatic logic [15:0] pack_rgb565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/dvp_timing_gen.sv
// Frame sequencer for the DVP transmitter.
// Walks VSYNC/VBP/ACTIVE/VFP line by line and exposes the current byte position.
module dvp_timing_gen
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP        = 17,
  parameter int V_FP        = 10
) (
  input  logic             cam_pclk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [CNT_W-1:0] hcnt,
  output logic             active,
  output logic             vsync,
  output logic             eof
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(2 * H_ACTIVE + H_BLANK - 1);

  dvp_state_e       state_r;
  dvp_state_e       next_state_s;
  logic [CNT_W-1:0] hcnt_r;
  logic [CNT_W-1:0] line_r;
  logic [CNT_W-1:0] line_last_s;

  // Line count and successor of the current state; enable only matters leaving IDLE or VFP.
  always_comb begin
    line_last_s  = {CNT_W{1'b0}};
    next_state_s = IDLE;
    case (state_r)
      VSYNC: begin
        line_last_s  = CNT_W'(VSYNC_LINES - 1);
        next_state_s = VBP;
      end
      VBP: begin
        line_last_s  = CNT_W'(V_BP - 1);
        next_state_s = ACTIVE;
      end
      ACTIVE: begin
        line_last_s  = CNT_W'(V_ACTIVE - 1);
        next_state_s = VFP;
      end
      VFP: begin
        line_last_s  = CNT_W'(V_FP - 1);
        next_state_s = enable ? VSYNC : IDLE;
      end
      default: begin
        line_last_s  = {CNT_W{1'b0}};
        next_state_s = enable ? VSYNC : IDLE;
      end
    endcase
  end

  // State, byte-within-line and line-within-state counters.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      hcnt_r  <= {CNT_W{1'b0}};
      line_r  <= {CNT_W{1'b0}};
    end else if (state_r == IDLE) begin
      state_r <= next_state_s;
      hcnt_r  <= {CNT_W{1'b0}};
      line_r  <= {CNT_W{1'b0}};
    end else if (hcnt_r == H_LAST) begin
      hcnt_r <= {CNT_W{1'b0}};
      if (line_r == line_last_s) begin
        line_r  <= {CNT_W{1'b0}};
        state_r <= next_state_s;
      end else begin
        line_r <= line_r + CNT_W'(1);
      end
    end else begin
      hcnt_r <= hcnt_r + CNT_W'(1);
    end
  end

  assign hcnt   = hcnt_r;
  assign active = (state_r == ACTIVE);
  assign vsync  = (state_r == VSYNC);
  assign eof    = (state_r == VFP) && (hcnt_r == H_LAST) && (line_r == line_last_s);

endmodule

// File: rtl/dvp_rgb565_tx.sv
// OV5640-style 8-bit DVP source: RGB888 valid/ready input, RGB565 two bytes per pixel.
// Every output is a flop one cycle behind the timing generator's position.
module dvp_rgb565_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 160,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP        = 17,
  parameter int V_FP        = 10
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_start,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  localparam logic [CNT_W-1:0] H_HREF = CNT_W'(2 * H_ACTIVE);

  logic [CNT_W-1:0] hcnt_s;
  logic             active_s;
  logic             vsync_s;
  logic             eof_s;
  logic             href_s;
  logic             even_s;
  logic             load_s;
  logic             full_next_s;
  logic             sof_s;
  logic [15:0]      pix565_s;
  logic [7:0]       data_next_s;
  logic             full_r;
  logic [23:0]      hold_r;
  logic [7:0]       odd_r;

  dvp_timing_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .H_BLANK     (H_BLANK),
    .V_ACTIVE    (V_ACTIVE),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BP        (V_BP),
    .V_FP        (V_FP)
  ) u_timing (
    .cam_pclk (cam_pclk),
    .rst_n    (rst_n),
    .enable   (enable),
    .hcnt     (hcnt_s),
    .active   (active_s),
    .vsync    (vsync_s),
    .eof      (eof_s)
  );

  assign href_s      = active_s && (hcnt_s < H_HREF);
  assign even_s      = href_s && !hcnt_s[0];
  assign load_s      = pix_valid && pix_ready;
  // An even slot always drains the register, even when a new pixel arrives on the same edge.
  assign full_next_s = load_s || (full_r && !even_s);
  assign sof_s       = vsync_s && !cam_vsync;
  assign pix565_s    = pack_rgb565(hold_r);

  // Byte selection: high byte from the holding register, low byte from the saved half.
  always_comb begin
    data_next_s = 8'h00;
    if (even_s) begin
      data_next_s = full_r ? pix565_s[15:8] : 8'h00;
    end else if (href_s) begin
      data_next_s = odd_r;
    end else begin
      data_next_s = 8'h00;
    end
  end

  // Holding register and handshake.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      full_r    <= 1'b0;
      pix_ready <= 1'b0;
      hold_r    <= 24'h000000;
      odd_r     <= 8'h00;
    end else begin
      full_r    <= full_next_s;
      pix_ready <= !full_next_s;
      if (load_s) begin
        hold_r <= pix_data;
      end
      if (even_s) begin
        odd_r <= full_r ? pix565_s[7:0] : 8'h00;
      end
    end
  end

  // DVP output flops, frame pulse, sticky underrun and frame counter.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cam_vsync   <= 1'b0;
      cam_href    <= 1'b0;
      cam_data    <= 8'h00;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      frame_cnt   <= 16'h0000;
    end else begin
      cam_vsync   <= vsync_s;
      cam_href    <= href_s;
      cam_data    <= data_next_s;
      frame_start <= sof_s;
      if (sof_s) begin
        underrun <= 1'b0;
      end else if (even_s && !full_r) begin
        underrun <= 1'b1;
      end
      if (eof_s) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
